// File: rtl/lsu_arbiter.sv
// Two-port round-robin arbiter in front of a single LSU/data-memory port.
// One transaction is in flight at a time; load data returns MEM_LAT cycles after o_mem_req.
`timescale 1ns/1ps

module lsu_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic        i_m0_req,
  input  logic        i_m0_wren,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_gnt,
  output logic        o_m0_done,
  output logic [31:0] o_m0_rdata,

  input  logic        i_m1_req,
  input  logic        i_m1_wren,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_gnt,
  output logic        o_m1_done,
  output logic [31:0] o_m1_rdata,

  output logic        o_mem_req,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic        ptr_q,   ptr_d;    // 1: port 1 wins a tie
  logic        owner_q, owner_d;
  logic        wren_q,  wren_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        gnt0, gnt1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    wren_d   = wren_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_m0_req && (!i_m1_req || !ptr_q)) begin
          gnt0    = 1'b1;
          owner_d = 1'b0;
          wren_d  = i_m0_wren;
          addr_d  = i_m0_addr;
          wdata_d = i_m0_wdata;
          ptr_d   = 1'b1;
          state_d = ISSUE;
        end else if (i_m1_req) begin
          gnt1    = 1'b1;
          owner_d = 1'b1;
          wren_d  = i_m1_wren;
          addr_d  = i_m1_addr;
          wdata_d = i_m1_wdata;
          ptr_d   = 1'b0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (wren_q) begin
          done0_d = !owner_q;
          done1_d = owner_q;
          state_d = IDLE;
        end else begin
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == 3'd0) begin
          done0_d = !owner_q;
          done1_d = owner_q;
          if (owner_q) rdata1_d = i_mem_rdata;
          else         rdata0_d = i_mem_rdata;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Grants are combinational, so they are masked while reset is held.
  assign o_m0_gnt    = gnt0 & i_rst_n;
  assign o_m1_gnt    = gnt1 & i_rst_n;
  assign o_m0_done   = done0_q;
  assign o_m1_done   = done1_q;
  assign o_m0_rdata  = rdata0_q;
  assign o_m1_rdata  = rdata1_q;

  assign o_mem_req   = (state_q == ISSUE);
  assign o_mem_wren  = o_mem_req & wren_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;

endmodule
